// File: rtl/gb_stream_host.sv
// Byte-stream command channel to single-word ghostbus write/read master.
// Latency: write strobe 1 cycle after last data byte; first response byte RD_LAT+1 cycles after last address byte.
// Backpressure: in_ready drops outside IDLE/ADDR/WDATA; response bytes hold while out_ready is low.
module gb_stream_host #(
    parameter int AW     = 24,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_dout,
    input  logic [DW-1:0] gb_din,
    output logic          gb_we,
    output logic [7:0]    err_cnt,
    output logic          busy
);
    localparam int ABYTES = (AW + 7) / 8;
    localparam int DBYTES = DW / 8;
    localparam logic [7:0] A_LAST = 8'(ABYTES - 1);
    localparam logic [7:0] D_LAST = 8'(DBYTES - 1);
    localparam logic [7:0] L_LAST = 8'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_WRITE,
        S_RWAIT,
        S_RESP
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    cnt;
    logic          wr_flag;
    logic [AW-1:0] addr_sr;
    logic [DW-1:0] data_sr;
    logic [DW-1:0] resp_sr;
    logic [AW-1:0] addr_nxt;
    logic [DW-1:0] data_nxt;
    logic          acc;
    logic          op_wr;
    logic          op_rd;

    assign acc      = in_valid & in_ready;
    assign op_wr    = (in_data == 8'h01);
    assign op_rd    = (in_data == 8'h02);
    // Casting drops the high bits of the first byte when AW/DW is not byte-aligned.
    assign addr_nxt = AW'({addr_sr, in_data});
    assign data_nxt = DW'({data_sr, in_data});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        gb_we     = 1'b0;
        out_valid = 1'b0;
        busy      = (state != S_IDLE);
        out_data  = resp_sr[DW-1 -: 8];
        case (state)
            S_IDLE:  if (acc && (op_wr || op_rd)) state_nxt = S_ADDR;
            S_ADDR:  if (acc && cnt == A_LAST) state_nxt = wr_flag ? S_WDATA : S_RWAIT;
            S_WDATA: if (acc && cnt == D_LAST) state_nxt = S_WRITE;
            S_WRITE: begin
                gb_we     = 1'b1;
                state_nxt = S_IDLE;
            end
            S_RWAIT: if (cnt == L_LAST) state_nxt = S_RESP;
            S_RESP: begin
                out_valid = 1'b1;
                if (out_ready && cnt == D_LAST) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready <= 1'b0;
            cnt      <= '0;
            wr_flag  <= 1'b0;
            addr_sr  <= '0;
            data_sr  <= '0;
            resp_sr  <= '0;
            gb_addr  <= '0;
            gb_dout  <= '0;
            err_cnt  <= '0;
        end else begin
            // Registered from next state so the cycle after a command's last byte is already blocked.
            in_ready <= (state_nxt == S_IDLE) || (state_nxt == S_ADDR) || (state_nxt == S_WDATA);
            case (state)
                S_IDLE: begin
                    cnt     <= '0;
                    addr_sr <= '0;
                    data_sr <= '0;
                    if (acc) begin
                        if (op_wr)                  wr_flag <= 1'b1;
                        else if (op_rd)             wr_flag <= 1'b0;
                        else if (err_cnt != 8'hFF)  err_cnt <= err_cnt + 8'd1;
                    end
                end
                S_ADDR: if (acc) begin
                    if (cnt == A_LAST) begin
                        cnt     <= '0;
                        gb_addr <= addr_nxt;
                    end else begin
                        cnt     <= cnt + 8'd1;
                        addr_sr <= addr_nxt;
                    end
                end
                S_WDATA: if (acc) begin
                    if (cnt == D_LAST) begin
                        cnt     <= '0;
                        gb_dout <= data_nxt;
                    end else begin
                        cnt     <= cnt + 8'd1;
                        data_sr <= data_nxt;
                    end
                end
                S_RWAIT: begin
                    if (cnt == L_LAST) begin
                        cnt     <= '0;
                        resp_sr <= gb_din;
                    end else begin
                        cnt     <= cnt + 8'd1;
                    end
                end
                S_RESP: if (out_ready) begin
                    resp_sr <= resp_sr << 8;
                    cnt     <= (cnt == D_LAST) ? 8'd0 : cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gb_stream_host.sv
// Directed bench for gb_stream_host: three instances (RD_LAT=1, RD_LAT=3, AW=12) share one stimulus port
// selected by sel; a negedge monitor records write strobes, response bytes and in_ready history.
// Bus model returns fixed words per address, delayed to match each instance's read latency.
module tb_gb_stream_host;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        out_ready;
    logic [1:0]  sel;
    logic [2:0]  iv, ir, ov, we, bz;
    logic [7:0]  od0, od1, od2, ec0, ec1, ec2;
    logic [23:0] ad0, ad1;
    logic [11:0] ad2;
    logic [31:0] dq0, dq1, dq2, din0, din1, din2, d1_pipe;

    assign iv = in_valid ? (3'b001 << sel) : 3'b000;

    gb_stream_host #(.AW(24), .DW(32), .RD_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(iv[0]), .in_ready(ir[0]),
        .out_data(od0), .out_valid(ov[0]), .out_ready(out_ready), .gb_addr(ad0), .gb_dout(dq0),
        .gb_din(din0), .gb_we(we[0]), .err_cnt(ec0), .busy(bz[0]));
    gb_stream_host #(.AW(24), .DW(32), .RD_LAT(3)) u_dut_lat3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(iv[1]), .in_ready(ir[1]),
        .out_data(od1), .out_valid(ov[1]), .out_ready(out_ready), .gb_addr(ad1), .gb_dout(dq1),
        .gb_din(din1), .gb_we(we[1]), .err_cnt(ec1), .busy(bz[1]));
    gb_stream_host #(.AW(12), .DW(32), .RD_LAT(1)) u_dut_aw12 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(iv[2]), .in_ready(ir[2]),
        .out_data(od2), .out_valid(ov[2]), .out_ready(out_ready), .gb_addr(ad2), .gb_dout(dq2),
        .gb_din(din2), .gb_we(we[2]), .err_cnt(ec2), .busy(bz[2]));

    function automatic logic [31:0] bus_lookup(input logic [23:0] a);
        case (a)
            24'h000001: return 32'h000000CC;
            24'h000100: return 32'hCECEFACE;
            24'h000ABC: return 32'h12345678;
            default:    return 32'hDEADBEEF;
        endcase
    endfunction

    assign din0 = bus_lookup(ad0);
    assign din2 = bus_lookup({12'h000, ad2});
    always @(posedge clk) begin
        d1_pipe <= bus_lookup(ad1);
        din1    <= d1_pipe;
    end

    logic        c_ir, c_ov, c_we, c_bz;
    logic [7:0]  c_od, c_ec;
    logic [23:0] c_ad;
    logic [31:0] c_dq;
    always_comb begin
        c_ir = ir[0]; c_ov = ov[0]; c_we = we[0]; c_bz = bz[0];
        c_od = od0; c_ec = ec0; c_ad = ad0; c_dq = dq0;
        if (sel == 2'd1) begin
            c_ir = ir[1]; c_ov = ov[1]; c_we = we[1]; c_bz = bz[1];
            c_od = od1; c_ec = ec1; c_ad = ad1; c_dq = dq1;
        end else if (sel == 2'd2) begin
            c_ir = ir[2]; c_ov = ov[2]; c_we = we[2]; c_bz = bz[2];
            c_od = od2; c_ec = ec2; c_ad = {12'h000, ad2}; c_dq = dq2;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  rx_q[$];
    int          we_cnt, we_cyc, ov_cyc, last_acc;
    logic [23:0] we_addr;
    logic [31:0] we_dat;
    bit          ov_seen, prev_stall;
    logic [7:0]  prev_od;
    bit          ir_hist [0:4095];

    always @(negedge clk) begin
        if (cyc < 4096) ir_hist[cyc] = c_ir;
        if (c_we) begin
            we_cnt++;
            we_cyc  = cyc;
            we_addr = c_ad;
            we_dat  = c_dq;
        end
        if (prev_stall) begin
            chk("ov_hold", {31'd0, c_ov}, 32'd1);
            chk("od_hold", {24'd0, c_od}, {24'd0, prev_od});
        end
        if (c_ov && !ov_seen) begin
            ov_seen = 1'b1;
            ov_cyc  = cyc;
        end
        if (c_ov && out_ready) rx_q.push_back(c_od);
        prev_stall = c_ov && !out_ready;
        prev_od    = c_od;
    end

    task automatic clr_mon();
        rx_q.delete();
        we_cnt = 0; we_cyc = -1; ov_cyc = -1;
        ov_seen = 1'b0; prev_stall = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!c_ir && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!c_ir) chk("in_ready_timeout", {31'd0, c_ir}, 32'd1);
        last_acc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_byte(v[8*i +: 8]);
    endtask

    task automatic wait_rx(input int n);
        int t;
        t = 0;
        while (rx_q.size() < n && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (rx_q.size() < n) chk("rx_timeout", rx_q.size(), n);
    endtask

    task automatic chk_word(input string tag, input logic [31:0] exp);
        chk({tag, "_cnt"}, rx_q.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_b%0d", tag, i), (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hFFFF_FFFF,
                {24'd0, exp[31-8*i -: 8]});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        logic [6:0] pat;
        sel = 2'd0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1; rst_n = 1'b0;
        clr_mon();
        #12;
        chk("rst_in_ready", {31'd0, c_ir}, 32'd0);
        chk("rst_out_valid", {31'd0, c_ov}, 32'd0);
        chk("rst_gb_we", {31'd0, c_we}, 32'd0);
        chk("rst_busy", {31'd0, c_bz}, 32'd0);
        chk("rst_err_cnt", {24'd0, c_ec}, 32'd0);
        chk("rst_gb_addr", {8'd0, c_ad}, 32'd0);
        chk("rst_out_data", {24'd0, c_od}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ir_first_low", {31'd0, c_ir}, 32'd0);
        @(negedge clk);
        chk("ir_first_high", {31'd0, c_ir}, 32'd1);
        @(posedge clk); #1;

        // Single write, back-to-back bytes.
        clr_mon();
        send_cmd(64'h01_000100_CECEFACE, 8);
        n = last_acc;
        wait_cyc(4);
        chk("wr_we_cnt", we_cnt, 32'd1);
        chk("wr_we_cyc", we_cyc, n + 1);
        chk("wr_addr", {8'd0, we_addr}, 32'h000100);
        chk("wr_dout", we_dat, 32'hCECEFACE);
        chk("wr_no_ov", {31'd0, ov_seen}, 32'd0);
        chk("wr_ir_low", {31'd0, ir_hist[n+1]}, 32'd0);
        chk("wr_ir_back", {31'd0, ir_hist[n+2]}, 32'd1);
        chk("wr_addr_hold", {8'd0, c_ad}, 32'h000100);

        // Read, RD_LAT=1.
        clr_mon();
        send_cmd(64'h02000001, 4);
        n = last_acc;
        wait_rx(4);
        wait_cyc(3);
        chk("rd1_first_ov", ov_cyc, n + 2);
        chk("rd1_addr", {8'd0, c_ad}, 32'h000001);
        chk_word("rd1", 32'h000000CC);

        // Read, RD_LAT=3.
        sel = 2'd1;
        clr_mon();
        send_cmd(64'h02000001, 4);
        n = last_acc;
        wait_rx(4);
        wait_cyc(3);
        chk("rd3_first_ov", ov_cyc, n + 4);
        chk_word("rd3", 32'h000000CC);

        // Response backpressure: out_ready 1,0,0,1,0,1,1 from the first RESP cycle.
        sel = 2'd0;
        clr_mon();
        send_cmd(64'h02000100, 4);
        n = last_acc;
        out_ready = 1'b0;
        @(posedge clk); #1;
        pat = 7'b1101001;
        for (int i = 0; i < 7; i++) begin
            out_ready = pat[i];
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_cyc(3);
        chk("bp_first_ov", ov_cyc, n + 2);
        chk_word("bp", 32'hCECEFACE);
        chk("bp_ir_last_low", {31'd0, ir_hist[n+8]}, 32'd0);
        chk("bp_ir_mid_low", {31'd0, ir_hist[n+4]}, 32'd0);
        chk("bp_ir_back", {31'd0, ir_hist[n+9]}, 32'd1);

        // Bad opcode, then a normal write, then saturation.
        clr_mon();
        send_byte(8'h7F);
        chk("bad_err_one", {24'd0, c_ec}, 32'd1);
        chk("bad_busy", {31'd0, c_bz}, 32'd0);
        send_cmd(64'h01_000020_11223344, 8);
        wait_cyc(3);
        chk("bad_we_cnt", we_cnt, 32'd1);
        chk("bad_wr_addr", {8'd0, we_addr}, 32'h000020);
        chk("bad_wr_dout", we_dat, 32'h11223344);
        chk("bad_err_keep", {24'd0, c_ec}, 32'd1);
        for (int i = 0; i < 299; i++) send_byte((i % 2 == 0) ? 8'h00 : 8'hFF);
        wait_cyc(2);
        chk("bad_err_sat", {24'd0, c_ec}, 32'h000000FF);
        chk("bad_sat_we", we_cnt, 32'd1);

        // Address truncation, AW=12.
        sel = 2'd2;
        clr_mon();
        send_cmd(64'h02FABC, 3);
        wait_rx(4);
        wait_cyc(2);
        chk("aw12_addr", {8'd0, c_ad}, 32'h000ABC);
        chk_word("aw12", 32'h12345678);

        // Reset during RESP after two bytes taken.
        sel = 2'd0;
        clr_mon();
        send_cmd(64'h02000100, 4);
        wait_rx(2);
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", {31'd0, c_ov}, 32'd0);
        chk("mrst_busy", {31'd0, c_bz}, 32'd0);
        chk("mrst_in_ready", {31'd0, c_ir}, 32'd0);
        chk("mrst_out_data", {24'd0, c_od}, 32'd0);
        chk("mrst_gb_addr", {8'd0, c_ad}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clr_mon();
        send_cmd(64'h02000001, 4);
        wait_rx(4);
        wait_cyc(4);
        chk_word("mrst_rd", 32'h000000CC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
